// File: rtl/cia_tod_access_arbiter_if.sv
// Requester and timer-register signals of the CIA TOD access arbiter.
// master = requesters plus timer model side, slave = the arbiter.
interface cia_tod_access_arbiter_if;
  logic [1:0]  req;
  logic [1:0]  we;
  logic [1:0]  alarm;
  logic [23:0] wdata0;
  logic [23:0] wdata1;
  logic [1:0]  ack;
  logic [23:0] rdata;
  logic        busy;
  logic        tod_wr;
  logic        tod_tlo;
  logic        tod_tme;
  logic        tod_thi;
  logic        tod_tcr;
  logic [7:0]  tod_dout;
  logic [7:0]  tod_din;

  modport master (
    output req, we, alarm, wdata0, wdata1, tod_din,
    input  ack, rdata, busy, tod_wr, tod_tlo, tod_tme, tod_thi, tod_tcr, tod_dout
  );

  modport slave (
    input  req, we, alarm, wdata0, wdata1, tod_din,
    output ack, rdata, busy, tod_wr, tod_tlo, tod_tme, tod_thi, tod_tcr, tod_dout
  );
endinterface

// File: rtl/cia_tod_access_arbiter.sv
// Two-requester arbiter that turns 24-bit TOD/alarm accesses into ordered
// byte strobes (MSB first, LSB last) so reads never tear and writes never half-land.
module cia_tod_access_arbiter (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clk7_en,
  cia_tod_access_arbiter_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_CR_CLR, S_CR_SET, S_HI, S_MID, S_LO, S_CR_POST, S_DONE
  } state_t;

  typedef struct packed {
    logic        id;
    logic        we;
    logic        alarm;
    logic [23:0] wdata;
  } xfer_t;

  typedef struct packed {
    logic       wr;
    logic       tcr;
    logic       thi;
    logic       tme;
    logic       tlo;
    logic [7:0] dout;
  } strobe_t;

  state_t      state, state_nxt;
  xfer_t       cur, gnt, xn;
  strobe_t     stb, stb_nxt;
  logic        ptr;
  logic        gid;
  logic        busy;
  logic [1:0]  ack;
  logic [15:0] rd_hold;
  logic [23:0] rdata;

  // Round-robin: the pointer owner wins if requesting, otherwise the other one.
  assign gid       = bus.req[ptr] ? ptr : ~ptr;
  assign gnt.id    = gid;
  assign gnt.we    = bus.we[gid];
  assign gnt.alarm = bus.alarm[gid];
  assign gnt.wdata = gid ? bus.wdata1 : bus.wdata0;

  // Strobes are registered from the next state, so the first state's strobe
  // needs the grant data before it has been latched into cur.
  assign xn = (state == S_IDLE) ? gnt : cur;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     state <= S_IDLE;
    else if (clk7_en) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (|bus.req)
                   state_nxt = !gnt.we ? S_HI : (gnt.alarm ? S_CR_SET : S_CR_CLR);
      S_CR_CLR:  state_nxt = S_HI;
      S_CR_SET:  state_nxt = S_HI;
      S_HI:      state_nxt = S_MID;
      S_MID:     state_nxt = S_LO;
      S_LO:      state_nxt = (cur.we && cur.alarm) ? S_CR_POST : S_DONE;
      S_CR_POST: state_nxt = S_DONE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    stb_nxt = '0;
    case (state_nxt)
      S_CR_CLR, S_CR_POST: begin
        stb_nxt.tcr = 1'b1;
        stb_nxt.wr  = 1'b1;
      end
      S_CR_SET: begin
        stb_nxt.tcr  = 1'b1;
        stb_nxt.wr   = 1'b1;
        stb_nxt.dout = 8'h80;
      end
      S_HI: begin
        stb_nxt.thi  = 1'b1;
        stb_nxt.wr   = xn.we;
        stb_nxt.dout = xn.we ? xn.wdata[23:16] : 8'h00;
      end
      S_MID: begin
        stb_nxt.tme  = 1'b1;
        stb_nxt.wr   = xn.we;
        stb_nxt.dout = xn.we ? xn.wdata[15:8] : 8'h00;
      end
      S_LO: begin
        stb_nxt.tlo  = 1'b1;
        stb_nxt.wr   = xn.we;
        stb_nxt.dout = xn.we ? xn.wdata[7:0] : 8'h00;
      end
      default: stb_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stb     <= '0;
      cur     <= '0;
      ptr     <= 1'b0;
      busy    <= 1'b0;
      rd_hold <= '0;
      rdata   <= '0;
    end else if (clk7_en) begin
      stb  <= stb_nxt;
      busy <= (state_nxt != S_IDLE);
      if (state == S_IDLE && |bus.req) begin
        cur <= gnt;
        ptr <= ~gid;
      end
      // rdata only moves once the whole word is in, so readers see no partial value.
      if (!cur.we) begin
        case (state)
          S_HI:    rd_hold[15:8] <= bus.tod_din;
          S_MID:   rd_hold[7:0]  <= bus.tod_din;
          S_LO:    rdata         <= {rd_hold, bus.tod_din};
          default: ;
        endcase
      end
    end
  end

  // ack clears on the very next clk, independent of the enable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                          ack <= '0;
    else if (clk7_en && state_nxt == S_DONE) ack <= 2'b01 << cur.id;
    else                                   ack <= '0;
  end

  assign bus.ack      = ack;
  assign bus.busy     = busy;
  assign bus.rdata    = rdata;
  assign bus.tod_wr   = stb.wr;
  assign bus.tod_tcr  = stb.tcr;
  assign bus.tod_thi  = stb.thi;
  assign bus.tod_tme  = stb.tme;
  assign bus.tod_tlo  = stb.tlo;
  assign bus.tod_dout = stb.dout;

endmodule

// File: tb/tb_cia_tod_access_arbiter.sv
// Bench for cia_tod_access_arbiter: behavioural CIA TOD timer plus expected
// strobe sequences built per access type, directed steps then random accesses.
module tb_cia_tod_access_arbiter;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  logic clk7_en = 1'b1;

  cia_tod_access_arbiter_if bus();

  cia_tod_access_arbiter dut (
    .clk     (clk),
    .reset_n (reset_n),
    .clk7_en (clk7_en),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int div    = 1;
  int en_cnt = 0;

  always @(negedge clk) begin
    en_cnt++;
    clk7_en = ((en_cnt % div) == 0);
  end

  logic [1:0]  req_s = '0;
  logic [1:0]  we_s  = '0;
  logic [1:0]  alm_s = '0;
  logic [23:0] wd_s [2];

  assign bus.req    = req_s;
  assign bus.we     = we_s;
  assign bus.alarm  = alm_s;
  assign bus.wdata0 = wd_s[0];
  assign bus.wdata1 = wd_s[1];

  // Behavioural CIA TOD: hold latch on MSB read, halt on MSB write, crb7 selects alarm.
  logic [23:0] tod       = '0;
  logic [23:0] alrm      = 24'hFFFFFF;
  logic [23:0] latch     = '0;
  logic [23:0] snap      = '0;
  logic        latched   = 1'b0;
  logic        halted    = 1'b0;
  logic        crb7      = 1'b0;
  logic        irq       = 1'b0;
  logic        tick_en   = 1'b0;
  logic        force_en  = 1'b0;
  logic [23:0] force_val = '0;
  logic [23:0] view;

  always @(posedge clk) begin
    if (clk7_en) begin
      if (force_en) tod <= force_val;
      else if (tick_en && !halted) begin
        tod <= tod + 24'd1;
        if (tod + 24'd1 == alrm) irq <= 1'b1;
      end
      if (bus.tod_thi && !bus.tod_wr) begin
        latch   <= tod;
        snap    <= tod;
        latched <= 1'b1;
      end
      if (bus.tod_tlo && !bus.tod_wr) latched <= 1'b0;
      if (bus.tod_wr) begin
        if (bus.tod_tcr) crb7 <= bus.tod_dout[7];
        if (bus.tod_thi) begin
          if (crb7) alrm[23:16] <= bus.tod_dout;
          else begin tod[23:16] <= bus.tod_dout; halted <= 1'b1; end
        end
        if (bus.tod_tme) begin
          if (crb7) alrm[15:8] <= bus.tod_dout;
          else      tod[15:8]  <= bus.tod_dout;
        end
        if (bus.tod_tlo) begin
          if (crb7) alrm[7:0] <= bus.tod_dout;
          else begin tod[7:0] <= bus.tod_dout; halted <= 1'b0; end
        end
      end
    end
  end

  always_comb begin
    view        = latched ? latch : tod;
    bus.tod_din = bus.tod_thi ? view[23:16] :
                  bus.tod_tme ? view[15:8]  :
                  bus.tod_tlo ? view[7:0]   : 8'h00;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk)
    if (reset_n)
      chk("onehot_sel", 32'($onehot0({bus.tod_tcr, bus.tod_thi, bus.tod_tme, bus.tod_tlo})), 1);

  function automatic logic [12:0] st(input logic wr, input logic [3:0] sel, input logic [7:0] d);
    return {wr, sel, d};
  endfunction

  function automatic logic [12:0] strobes_now();
    return {bus.tod_wr, bus.tod_tcr, bus.tod_thi, bus.tod_tme, bus.tod_tlo, bus.tod_dout};
  endfunction

  task automatic step_en();
    do @(posedge clk); while (!clk7_en);
    #1;
  endtask

  int rr     = 0;
  int last_w = 0;

  // Runs one access from grant to DONE exit; winner comes from the round-robin model.
  task automatic do_txn(input logic [1:0] mask);
    logic [12:0] exp_q [$];
    logic        wwe, walm;
    logic [23:0] wd;
    int          w, k;
    w    = (mask == 2'b11) ? rr : (mask[1] ? 1 : 0);
    wwe  = we_s[w];
    walm = alm_s[w];
    wd   = wd_s[w];
    if (!wwe) begin
      exp_q.push_back(st(1'b0, 4'b0100, 8'h00));
      exp_q.push_back(st(1'b0, 4'b0010, 8'h00));
      exp_q.push_back(st(1'b0, 4'b0001, 8'h00));
    end else begin
      exp_q.push_back(st(1'b1, 4'b1000, walm ? 8'h80 : 8'h00));
      exp_q.push_back(st(1'b1, 4'b0100, wd[23:16]));
      exp_q.push_back(st(1'b1, 4'b0010, wd[15:8]));
      exp_q.push_back(st(1'b1, 4'b0001, wd[7:0]));
      if (walm) exp_q.push_back(st(1'b1, 4'b1000, 8'h00));
    end
    for (k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (bus.busy) break;
    end
    if (k == 200) begin chk("grant_timeout", 0, 1); return; end
    chk("busy_at_grant", 32'(bus.busy), 1);
    for (int i = 0; i < exp_q.size(); i++) begin
      chk($sformatf("strobe%0d", i), 32'(strobes_now()), 32'(exp_q[i]));
      chk($sformatf("no_ack%0d", i), 32'(bus.ack), 0);
      step_en();
    end
    chk("ack", 32'(bus.ack), 32'(2'b01 << w));
    chk("done_quiet", 32'(strobes_now()), 0);
    if (!wwe) chk("rdata", 32'(bus.rdata), 32'(snap));
    @(posedge clk); #1;
    chk("ack_width", 32'(bus.ack), 0);
    for (k = 0; k < 50 && bus.busy; k++) begin @(posedge clk); #1; end
    if (bus.busy) chk("busy_timeout", 1, 0);
    last_w = w;
    rr     = 1 - w;
  endtask

  initial begin
    wd_s[0] = '0;
    wd_s[1] = '0;

    // Reset state
    #2 reset_n = 1'b0;
    #2;
    chk("rst_ack", 32'(bus.ack), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_rdata", 32'(bus.rdata), 0);
    chk("rst_strobes", 32'(strobes_now()), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Read by requester 0 with the TOD ticking every enabled edge
    @(posedge clk); #1;
    force_val = 24'h123455;
    force_en  = 1'b1;
    @(posedge clk); #1;
    force_en = 1'b0;
    tick_en  = 1'b1;
    we_s     = 2'b00;
    req_s    = 2'b01;
    do_txn(2'b01);
    req_s   = 2'b00;
    tick_en = 1'b0;
    chk("read_123456", 32'(bus.rdata), 32'h123456);

    // TOD write by requester 1, then read back
    we_s = 2'b10; alm_s = 2'b00; wd_s[1] = 24'hABCDEF;
    req_s = 2'b10;
    do_txn(2'b10);
    req_s = 2'b00;
    chk("tod_written", 32'(tod), 32'hABCDEF);
    we_s = 2'b00;
    req_s = 2'b01;
    do_txn(2'b01);
    req_s = 2'b00;
    chk("read_abcdef", 32'(bus.rdata), 32'hABCDEF);

    // Alarm write 0x10, then TOD write 0x0F with ticks -> irq
    we_s = 2'b01; alm_s = 2'b01; wd_s[0] = 24'h000010;
    req_s = 2'b01;
    do_txn(2'b01);
    req_s = 2'b00;
    chk("alarm_reg", 32'(alrm), 32'h000010);
    chk("crb7_after_alarm", 32'(crb7), 0);
    chk("irq_before", 32'(irq), 0);
    tick_en = 1'b1;
    we_s = 2'b10; alm_s = 2'b00; wd_s[1] = 24'h00000F;
    req_s = 2'b10;
    do_txn(2'b10);
    req_s = 2'b00;
    repeat (4) step_en();
    tick_en = 1'b0;
    chk("irq_fired", 32'(irq), 1);
    chk("crb7_final", 32'(crb7), 0);

    // Both requesting continuously: grants alternate
    we_s  = 2'b00;
    req_s = 2'b11;
    for (int i = 0; i < 4; i++) begin
      int prev;
      prev = last_w;
      do_txn(2'b11);
      if (i > 0) chk($sformatf("alternate%0d", i), 32'(last_w), 32'(1 - prev));
    end
    req_s = 2'b00;

    // Reset during MID of a requester-0 write (pointer moved to 1 at grant)
    we_s = 2'b01; alm_s = 2'b00; wd_s[0] = 24'h5A5A5A;
    req_s = 2'b01;
    begin
      int k;
      for (k = 0; k < 50; k++) begin
        @(posedge clk); #1;
        if (bus.tod_tme) break;
      end
      if (k == 50) chk("mid_timeout", 0, 1);
    end
    #2;
    reset_n = 1'b0;
    req_s   = 2'b00;
    #1;
    chk("rst_mid_strobes", 32'(strobes_now()), 0);
    chk("rst_mid_ack", 32'(bus.ack), 0);
    chk("rst_mid_busy", 32'(bus.busy), 0);
    chk("rst_mid_rdata", 32'(bus.rdata), 0);
    @(negedge clk);
    reset_n = 1'b1;
    rr = 0;
    @(posedge clk); #1;
    we_s  = 2'b00;
    req_s = 2'b11;
    do_txn(2'b11);
    chk("post_rst_first", 32'(last_w), 0);
    req_s = 2'b10;
    do_txn(2'b10);
    req_s = 2'b00;

    // Quarter-rate enable: same sequences, one-clk ack
    div = 4;
    we_s = 2'b10; alm_s = 2'b00; wd_s[1] = 24'h314159;
    req_s = 2'b10;
    do_txn(2'b10);
    req_s = 2'b00;
    we_s = 2'b00;
    req_s = 2'b01;
    do_txn(2'b01);
    req_s = 2'b00;
    chk("slow_read", 32'(bus.rdata), 32'h314159);

    // Random accesses
    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(0, 2))
        0: div = 1;
        1: div = 2;
        default: div = 4;
      endcase
      we_s    = 2'($urandom_range(0, 3));
      alm_s   = 2'($urandom_range(0, 3));
      wd_s[0] = 24'($urandom);
      wd_s[1] = 24'($urandom);
      begin
        logic [1:0] m;
        m = 2'($urandom_range(1, 3));
        req_s = m;
        do_txn(m);
      end
      req_s = 2'b00;
      if (we_s[last_w]) begin
        if (alm_s[last_w]) chk("rnd_alarm", 32'(alrm), 32'(wd_s[last_w]));
        else               chk("rnd_tod", 32'(tod), 32'(wd_s[last_w]));
        chk("rnd_crb7", 32'(crb7), 0);
      end else begin
        chk("rnd_read", 32'(bus.rdata), 32'(tod));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cia_tod_access_arbiter.md
# cia_tod_access_arbiter

Sequences atomic 24-bit accesses to a CIA time-of-day (TOD) counter and its alarm on behalf of two requesters (e.g. RTC sync agent, OSD/debug port). It generates the byte-wide register strobes (LSB/MID/MSB/control-register) in the order the TOD latch and stop/start rules require, so a requester never sees a torn read or a half-written counter. It sits between the requesters and the timer's register port, in the clk7_en domain.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock (single clock).
- reset_n  in  1  asynchronous, active-low reset.
- clk7_en  in  1  clock enable; all state advances only on clk edges with clk7_en=1.
- req[1:0]  in  2  per-requester request level; held until matching ack.
- we[1:0]  in  2  per-requester 1=write, 0=read; sampled at grant.
- alarm[1:0]  in  2  per-requester write target 1=alarm, 0=TOD; ignored for reads.
- wdata0, wdata1  in  24 each  write data; sampled at grant.
- ack[1:0]  out  2  one-clk pulse on completion.
- rdata  out  24  read result; valid from ack, held until next read completes.
- busy  out  1  high from grant until DONE state exits.
- tod_wr  out  1  timer write enable (0 = read).
- tod_tlo, tod_tme, tod_thi, tod_tcr  out  1 each  timer byte selects.
- tod_dout  out  8  data to timer.
- tod_din  in  8  data from timer (combinational read path).

## Operation
- FSM states: IDLE, CR_CLR, CR_SET, HI, MID, LO, CR_POST, DONE. Every transition occurs on an enabled edge.
- IDLE: if any req, grant via round-robin. The pointer starts at requester 0 and moves to the non-granted requester after each grant. Latch the winner's id, we, alarm and wdata, then branch:
  - read: HI, MID, LO.
  - TOD write: CR_CLR, HI, MID, LO.
  - alarm write: CR_SET, HI, MID, LO, CR_POST.
- The last step of each sequence goes to DONE. DONE goes to IDLE.
- Strobes per state are registered; exactly one select is high, all others 0:
  - CR_CLR: tcr, wr=1, dout=0x00.
  - CR_SET: tcr, wr=1, dout=0x80.
  - CR_POST: tcr, wr=1, dout=0x00.
  - HI/MID/LO: thi/tme/tlo, with wr=we and dout=wdata[23:16]/[15:8]/[7:0] for writes, dout=0x00 for reads.
  - IDLE, DONE: all selects 0, wr=0, dout=0x00.
- Read capture: on the enabled edge leaving HI/MID/LO, capture tod_din into rdata[23:16]/[15:8]/[7:0]. MSB is read first so the timer's hold latch freezes. LSB is read last so it releases.
- Write ordering: MSB first stops the counter, LSB last restarts it. The control-register write with bit7=0 (CR_CLR, CR_POST) also starts counting; this is intended.
- ack[id] is asserted on the edge entering DONE and cleared on the next clk edge regardless of clk7_en.
- If req drops mid-sequence, the sequence still completes and ack still pulses.
- Simultaneous req[0] and req[1] in IDLE: the pointer decides. Back-to-back requests therefore alternate.
- Reset (async, any state): state=IDLE, pointer=0, ack=0, busy=0, rdata=0, all strobes 0, tod_dout=0x00. Strobes drop immediately; a partial sequence is abandoned.

## Timing
- Let e0 be the enabled edge on which IDLE grants. The state's strobes are valid from the following edge.
- Read: strobes e0..e3, ack at e3.
- TOD write: strobes e0..e4, ack at e4.
- Alarm write: strobes e0..e5, ack at e5.
- Each strobe lasts exactly one enabled period.
- DONE lasts one enabled period, then IDLE for at least one. The earliest next grant is 2 enabled edges after ack, which gives requesters time to drop req.
- clk7_en low: everything holds except ack clearing.

## Test plan
- Read, requester 0, timer TOD=0x12_34_56: strobe order thi, tme, tlo with wr=0. ack[0] at e3. rdata=0x123456. The TOD increment between thi and tlo must not alter rdata.
- TOD write, requester 1, wdata=0xABCDEF: sequence tcr/0x00, thi/0xAB, tme/0xCD, tlo/0xEF. ack[1] at e4. A subsequent read returns 0xABCDEF (+ticks).
- Alarm write 0x000010 then TOD write 0x00000F with ticks enabled: sequence tcr/0x80, thi, tme, tlo, tcr/0x00. The timer irq fires at 0x000010, and crb7 ends at 0.
- req[0]=req[1]=1 continuously: grants alternate 0, 1, 0, 1. Exactly one ack per sequence, and never two strobes high at once.
- reset_n pulsed low during MID of a write: all strobes 0 immediately with no ack. After release, a pending req[1] is granted first only if req[0] is low (pointer=0).
- clk7_en at 1/4 duty: sequence lengths are identical in enabled edges, and ack width is exactly one clk.
